// File: rtl/rx_iq_packetizer_pkg.sv
// Shared constants and state encoding for the Rx I&Q packetizer.
// Header layout: seq(4) timestamp(8) bits/sample(2) samples/frame(2).
package rx_iq_packetizer_pkg;

  localparam int HDR_LEN          = 16;
  localparam int BITS_PER_SAMPLE  = 24;
  localparam int BYTES_PER_SAMPLE = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    REQ  = 3'd2,
    HDR  = 3'd3,
    PAY  = 3'd4,
    DONE = 3'd5
  } pk_state_t;

endpackage

// File: rtl/rx_iq_packetizer_if.sv
// Packetizer to Ethernet Tx arbiter link.
// master = packetizer, slave = arbiter.
interface rx_iq_packetizer_if;

  logic       tx_req;
  logic       tx_grant;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_sop;
  logic       tx_eop;

  modport master (
    output tx_req,
    output tx_data,
    output tx_valid,
    output tx_sop,
    output tx_eop,
    input  tx_grant
  );

  modport slave (
    input  tx_req,
    input  tx_data,
    input  tx_valid,
    input  tx_sop,
    input  tx_eop,
    output tx_grant
  );

endinterface

// File: rtl/rx_iq_packetizer.sv
// Frames one receiver's Rx byte FIFO stream into DDC I&Q UDP payloads.
// Frame = 16-byte header + SPF*6 sample bytes, streamed after arbiter grant.
module rx_iq_packetizer
  import rx_iq_packetizer_pkg::*;
#(
  parameter int          SPF      = 238,
  parameter int          CNT_W    = 11,
  parameter logic [31:0] SEQ_INIT = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] fifo_rdusedw,
  input  logic [7:0]       fifo_q,
  input  logic             fifo_clear,
  output logic             fifo_rdreq,
  input  logic [63:0]      timestamp,
  rx_iq_packetizer_if.master tx,
  output logic             underflow
);

  localparam int PAY_BYTES = SPF * BYTES_PER_SAMPLE;

  localparam logic [CNT_W-1:0] PAY_LEN  = CNT_W'(PAY_BYTES);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_BYTES - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [15:0]      SPF16    = 16'(SPF);
  localparam logic [15:0]      BPS16    = 16'(BITS_PER_SAMPLE);

  pk_state_t        state;
  pk_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      seq;
  logic [63:0]      ts_q;
  logic             run_d;
  logic             run_rise;
  logic             frame_rdy;
  logic [7:0]       hdr_byte;

  assign run_rise  = run & ~run_d;
  assign frame_rdy = (fifo_rdusedw >= PAY_LEN) & ~fifo_clear;

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: a granted frame always runs to completion
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (run) state_nxt = WAIT;
      WAIT: begin
        if (!run)           state_nxt = IDLE;
        else if (frame_rdy) state_nxt = REQ;
      end
      REQ:  if (tx.tx_grant)     state_nxt = HDR;
      HDR:  if (cnt == HDR_LAST) state_nxt = PAY;
      PAY:  if (cnt == PAY_LAST) state_nxt = DONE;
      DONE: state_nxt = run ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // byte counter restarts on every state change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else if (state == HDR || state == PAY)
      cnt <= cnt + CNT_W'(1);
  end

  // sequence number, timestamp latch, run edge tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq   <= SEQ_INIT;
      ts_q  <= '0;
      run_d <= 1'b0;
    end else begin
      run_d <= run;
      if (state == IDLE && run_rise)
        seq <= SEQ_INIT;
      else if (state == DONE)
        seq <= seq + 32'd1;
      if (state == REQ && tx.tx_grant)
        ts_q <= timestamp;
    end
  end

  // sticky underflow: FIFO flushed under a streaming payload
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      underflow <= 1'b0;
    else if (state == IDLE && run_rise)
      underflow <= 1'b0;
    else if (state == PAY && fifo_clear)
      underflow <= 1'b1;
  end

  // header byte select, MSB first
  always_comb begin
    hdr_byte = '0;
    unique case (cnt[3:0])
      4'd0:  hdr_byte = seq[31:24];
      4'd1:  hdr_byte = seq[23:16];
      4'd2:  hdr_byte = seq[15:8];
      4'd3:  hdr_byte = seq[7:0];
      4'd4:  hdr_byte = ts_q[63:56];
      4'd5:  hdr_byte = ts_q[55:48];
      4'd6:  hdr_byte = ts_q[47:40];
      4'd7:  hdr_byte = ts_q[39:32];
      4'd8:  hdr_byte = ts_q[31:24];
      4'd9:  hdr_byte = ts_q[23:16];
      4'd10: hdr_byte = ts_q[15:8];
      4'd11: hdr_byte = ts_q[7:0];
      4'd12: hdr_byte = BPS16[15:8];
      4'd13: hdr_byte = BPS16[7:0];
      4'd14: hdr_byte = SPF16[15:8];
      4'd15: hdr_byte = SPF16[7:0];
    endcase
  end

  // outputs: FIFO read runs one clock ahead of the payload bytes
  always_comb begin
    fifo_rdreq  = 1'b0;
    tx.tx_req   = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_sop   = 1'b0;
    tx.tx_eop   = 1'b0;
    tx.tx_data  = '0;
    unique case (state)
      REQ: tx.tx_req = 1'b1;
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_sop   = (cnt == '0);
        tx.tx_data  = hdr_byte;
        fifo_rdreq  = (cnt == HDR_LAST);
      end
      PAY: begin
        tx.tx_valid = 1'b1;
        tx.tx_eop   = (cnt == PAY_LAST);
        tx.tx_data  = fifo_q;
        fifo_rdreq  = (cnt != PAY_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rx_iq_packetizer.sv
// Directed bench for rx_iq_packetizer.
// Second instance starts its sequence at 0xFFFFFFFF to exercise wrap.
module tb_rx_iq_packetizer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        fifo_clear = 1'b0;
  logic [10:0] rdusedw = '0;
  logic [7:0]  fifo_q = '0;
  logic [7:0]  fptr = '0;
  logic        fifo_rst = 1'b0;
  logic        rdreq;
  logic        rdreq2;
  logic        uf;
  logic        uf2;
  logic [63:0] ts = 64'h0123_4567_89AB_CDEF;
  int          n_vec = 0;
  int          n_err = 0;

  rx_iq_packetizer_if tx ();
  rx_iq_packetizer_if tx2 ();

  assign tx2.tx_grant = tx.tx_grant;

  rx_iq_packetizer u_dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .fifo_rdusedw (rdusedw),
    .fifo_q       (fifo_q),
    .fifo_clear   (fifo_clear),
    .fifo_rdreq   (rdreq),
    .timestamp    (ts),
    .tx           (tx),
    .underflow    (uf)
  );

  rx_iq_packetizer #(.SEQ_INIT(32'hFFFF_FFFF)) u_dut2 (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .fifo_rdusedw (rdusedw),
    .fifo_q       (fifo_q),
    .fifo_clear   (fifo_clear),
    .fifo_rdreq   (rdreq2),
    .timestamp    (ts),
    .tx           (tx2),
    .underflow    (uf2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ts <= ts + 64'd1;

  always @(posedge clock) begin
    if (fifo_rst) fptr <= '0;
    else if (rdreq) begin
      fifo_q <= fptr;
      fptr   <= fptr + 8'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {tx.tx_req, tx.tx_valid, tx.tx_sop, tx.tx_eop,
            rdreq, uf, tx.tx_data};
  endfunction

  task automatic xfer(input int gdly,
                      input logic [31:0] eseq,
                      input logic [31:0] eseq2,
                      input int drop_at,
                      input int clr_at,
                      input int rst_at);
    int k, n, sops, eidx, perr, nrd, nrd2;
    logic [31:0] sq, sq2, tail;
    logic [63:0] tsv, tse;
    logic [7:0]  b;
    k = 0; n = 0; sops = 0; eidx = -1;
    perr = 0; nrd = 0; nrd2 = 0;
    sq = '0; sq2 = '0; tail = '0; tsv = '0;
    while (!tx.tx_req && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("req_seen", 64'(tx.tx_req), 64'd1);
    if (!tx.tx_req) return;
    repeat (gdly) @(negedge clock);
    chk("req_hold", 64'(tx.tx_req), 64'd1);
    tx.tx_grant = 1'b1;
    fifo_rst    = 1'b1;
    tse         = ts;
    @(negedge clock);
    tx.tx_grant = 1'b0;
    fifo_rst    = 1'b0;
    chk("g2sop", 64'(tx.tx_sop), 64'd1);
    for (int i = 0; i < 2000 && tx.tx_valid; i++) begin
      b = tx.tx_data;
      sops += int'(tx.tx_sop);
      if (tx.tx_eop) eidx = n;
      nrd  += int'(rdreq);
      nrd2 += int'(rdreq2);
      if (n < 4) begin
        sq  = {sq[23:0], b};
        sq2 = {sq2[23:0], tx2.tx_data};
      end else if (n < 12) tsv = {tsv[55:0], b};
      else if (n < 16) tail = {tail[23:0], b};
      else if (clr_at < 0 && b != 8'(n - 16)) perr++;
      if (rst_at >= 0 && n == rst_at) begin
        #2 reset = 1'b0;
        #1 chk("rst_mid", 64'(outs()), 64'd0);
        return;
      end
      fifo_clear = (clr_at >= 0 && n - 16 == clr_at);
      if (clr_at >= 0 && n - 16 == clr_at) rdusedw = '0;
      if (drop_at >= 0 && n - 16 == drop_at) run = 1'b0;
      n++;
      @(negedge clock);
    end
    fifo_clear = 1'b0;
    chk("len", 64'(n), 64'd1444);
    chk("eop_idx", 64'(eidx), 64'd1443);
    chk("sop_n", 64'(sops), 64'd1);
    chk("seq", 64'(sq), 64'(eseq));
    chk("seq2", 64'(sq2), 64'(eseq2));
    chk("ts", tsv, tse);
    chk("bps_spf", 64'(tail), 64'h0018_00EE);
    chk("rdreq_n", 64'(nrd), 64'd1428);
    chk("rdreq2_n", 64'(nrd2), 64'd1428);
    if (clr_at < 0) chk("payload", 64'(perr), 64'd0);
  endtask

  initial begin
    int k;
    tx.tx_grant = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_outs", 64'(outs()), 64'd0);
    reset   = 1'b1;
    run     = 1'b1;
    rdusedw = 11'd1427;
    k = 0;
    repeat (20) begin
      @(negedge clock);
      k += int'(tx.tx_req);
    end
    chk("req_1427", 64'(k), 64'd0);
    tx.tx_grant = 1'b1;
    repeat (2) @(negedge clock);
    chk("stray_gnt", 64'({tx.tx_valid, tx.tx_req}), 64'd0);
    tx.tx_grant = 1'b0;
    rdusedw = 11'd1428;
    @(negedge clock);
    chk("req_1428", 64'(tx.tx_req), 64'd1);

    xfer(3, 32'h0, 32'hFFFF_FFFF, -1, -1, -1);
    xfer(0, 32'h1, 32'h0, -1, -1, -1);
    xfer(1, 32'h2, 32'h1, 100, -1, -1);
    k = 0;
    repeat (30) begin
      @(negedge clock);
      k += int'(tx.tx_req) + int'(tx.tx_valid);
    end
    chk("idle_quiet", 64'(k), 64'd0);

    run = 1'b1;
    xfer(2, 32'h0, 32'hFFFF_FFFF, -1, 500, -1);
    chk("uf_set", 64'(uf), 64'd1);
    chk("uf2_set", 64'(uf2), 64'd1);
    run = 1'b0;
    repeat (3) @(negedge clock);
    chk("uf_sticky", 64'(uf), 64'd1);
    run = 1'b1;
    @(negedge clock);
    chk("uf_clr", 64'(uf), 64'd0);

    rdusedw = 11'd1428;
    xfer(1, 32'h0, 32'hFFFF_FFFF, -1, -1, -1);
    xfer(1, 32'h1, 32'h0, -1, -1, 7);
    @(negedge clock);
    reset = 1'b1;
    xfer(2, 32'h0, 32'hFFFF_FFFF, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
